// File: rtl/modport_block.sv
// Byte-wide CPU register block in front of a receive packet buffer.
// Upstream bytes land in a byte FIFO; software drains whole packets through an 8-register map.
module modport_block #(
    parameter int         DEPTH     = 16,
    parameter int         PKT_SLOTS = 4,
    parameter logic [7:0] ID_VALUE  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] addr,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       rd,
    output logic [7:0] rd_data,
    output logic       int_n,
    input  logic       pkt_valid,
    input  logic [7:0] pkt_data,
    input  logic       pkt_last,
    output logic       pkt_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = (PKT_SLOTS > 1) ? $clog2(PKT_SLOTS) : 1;
    localparam int CW = $clog2(PKT_SLOTS + 1);

    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [CW-1:0] SLOTS_C   = CW'(PKT_SLOTS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(PKT_SLOTS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic [2:0] {
        A_CTRL    = 3'd0,
        A_STATUS  = 3'd1,
        A_RX_LEN  = 3'd2,
        A_RX_DATA = 3'd3,
        A_SCRATCH = 3'd4,
        A_PKT_CNT = 3'd5,
        A_ID      = 3'd6,
        A_RSVD    = 3'd7
    } reg_addr_e;

    logic          enable_q, enable_d;
    logic          int_en_q, int_en_d;
    logic [7:0]    scratch_q, scratch_d;
    logic          overflow_q, overflow_d;
    logic          dropping_q, dropping_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          int_n_q, int_n_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] part_len_q, part_len_d;
    logic [LW-1:0] head_used_q, head_used_d;
    logic [SW-1:0] len_wr_q, len_wr_d;
    logic [SW-1:0] len_rd_q, len_rd_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [7:0]    byte_mem [DEPTH];
    logic [LW-1:0] len_mem  [PKT_SLOTS];

    reg_addr_e     reg_sel;
    logic [AW:0]   byte_cnt;
    logic          byte_full, byte_empty, len_full, pkt_avail;
    logic [LW-1:0] head_len, rx_len;
    logic          accept, flush, pop, head_done, ovf_now;
    logic          byte_we, len_we;
    logic [7:0]    rd_mux;

    assign reg_sel    = reg_addr_e'(addr);
    assign byte_cnt   = wr_ptr_q - rd_ptr_q;
    assign byte_full  = (byte_cnt == DEPTH_C);
    assign byte_empty = (byte_cnt == '0);
    assign len_full   = (pkt_cnt_q == SLOTS_C);
    assign pkt_avail  = (pkt_cnt_q != '0);
    assign head_len   = len_mem[len_rd_q];
    assign rx_len     = pkt_avail ? (head_len - head_used_q) : '0;

    // While discarding an overflowed packet the port keeps draining so the
    // sender can reach its pkt_last.
    assign pkt_ready  = enable_q & (dropping_q | (~byte_full & ~len_full));
    assign accept     = pkt_valid & pkt_ready;
    assign flush      = wr & (reg_sel == A_CTRL) & wr_data[2];
    assign pop        = rd & (reg_sel == A_RX_DATA) & pkt_avail;
    assign head_done  = pop & ((head_used_q + LEN_ONE) == head_len);

    // A full FIFO with no complete packet can only hold one partial packet
    // that will never fit; without this rewind the port would deadlock.
    assign ovf_now    = byte_full & ~pkt_avail & ~dropping_q;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            A_CTRL:    rd_mux = {6'b0, int_en_q, enable_q};
            A_STATUS:  rd_mux = {4'b0, byte_empty, overflow_q, byte_full, pkt_avail};
            A_RX_LEN:  rd_mux = 8'(rx_len);
            A_RX_DATA: rd_mux = pkt_avail ? byte_mem[rd_ptr_q[AW-1:0]] : 8'h00;
            A_SCRATCH: rd_mux = scratch_q;
            A_PKT_CNT: rd_mux = 8'(pkt_cnt_q);
            A_ID:      rd_mux = ID_VALUE;
            A_RSVD:    rd_mux = 8'h00;
            default:   rd_mux = 8'h00;
        endcase
    end

    // NOTE: every variable assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        enable_d    = enable_q;
        int_en_d    = int_en_q;
        scratch_d   = scratch_q;
        overflow_d  = overflow_q;
        dropping_d  = dropping_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        part_len_d  = part_len_q;
        head_used_d = head_used_q;
        len_wr_d    = len_wr_q;
        len_rd_d    = len_rd_q;
        pkt_cnt_d   = pkt_cnt_q;
        byte_we     = 1'b0;
        len_we      = 1'b0;

        if (wr && reg_sel == A_CTRL) begin
            enable_d = wr_data[0];
            int_en_d = wr_data[1];
        end
        if (wr && reg_sel == A_SCRATCH) begin
            scratch_d = wr_data;
        end
        if (wr && reg_sel == A_STATUS && wr_data[2]) begin
            overflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            part_len_d  = '0;
            head_used_d = '0;
            len_wr_d    = '0;
            len_rd_d    = '0;
            pkt_cnt_d   = '0;
            dropping_d  = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                head_used_d = head_done ? '0 : head_used_q + LEN_ONE;
                if (head_done) begin
                    len_rd_d = (len_rd_q == SLOT_LAST) ? '0 : len_rd_q + SLOT_ONE;
                end
            end

            if (ovf_now) begin
                wr_ptr_d   = wr_ptr_q - (AW + 1)'(part_len_q);
                part_len_d = '0;
                dropping_d = 1'b1;
                overflow_d = 1'b1;
            end else if (accept) begin
                if (dropping_q) begin
                    dropping_d = ~pkt_last;
                end else begin
                    byte_we  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (pkt_last) begin
                        len_we     = 1'b1;
                        len_wr_d   = (len_wr_q == SLOT_LAST) ? '0 : len_wr_q + SLOT_ONE;
                        part_len_d = '0;
                    end else begin
                        part_len_d = part_len_q + LEN_ONE;
                    end
                end
            end

            pkt_cnt_d = pkt_cnt_q + CW'(len_we) - CW'(head_done);
        end

        rd_data_d = rd ? rd_mux : rd_data_q;
        int_n_d   = ~(int_en_q & pkt_avail);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q    <= 1'b0;
            int_en_q    <= 1'b0;
            scratch_q   <= 8'h00;
            overflow_q  <= 1'b0;
            dropping_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            int_n_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            part_len_q  <= '0;
            head_used_q <= '0;
            len_wr_q    <= '0;
            len_rd_q    <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            enable_q    <= enable_d;
            int_en_q    <= int_en_d;
            scratch_q   <= scratch_d;
            overflow_q  <= overflow_d;
            dropping_q  <= dropping_d;
            rd_data_q   <= rd_data_d;
            int_n_q     <= int_n_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            part_len_q  <= part_len_d;
            head_used_q <= head_used_d;
            len_wr_q    <= len_wr_d;
            len_rd_q    <= len_rd_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // NOTE: storage arrays have no reset; the cleared pointers and counters
    // make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (byte_we) begin
            byte_mem[wr_ptr_q[AW-1:0]] <= pkt_data;
        end
        if (len_we) begin
            len_mem[len_wr_q] <= part_len_q + LEN_ONE;
        end
    end

    assign rd_data = rd_data_q;
    assign int_n   = int_n_q;

endmodule

// File: tb/tb_modport_block.sv
// Self-checking bench for modport_block: directed steps plus randomized traffic
// compared against a queue-based packet model.
module tb_modport_block;
    localparam int DEPTH = 16;
    localparam int SLOTS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] addr = 3'd0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] rd_data;
    logic       int_n;
    logic       pkt_valid = 1'b0;
    logic [7:0] pkt_data = 8'h00;
    logic       pkt_last = 1'b0;
    logic       pkt_ready;

    always #5 clk = ~clk;

    modport_block #(.DEPTH(DEPTH), .PKT_SLOTS(SLOTS), .ID_VALUE(8'hA5)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .wr_data(wr_data), .rd(rd),
        .rd_data(rd_data), .int_n(int_n), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_last(pkt_last), .pkt_ready(pkt_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: committed bytes, remaining length per stored packet, partial packet.
    logic [7:0] m_bytes[$];
    int         m_lens[$];
    logic [7:0] m_part[$];
    bit         m_drop, m_ovf, m_en, m_ie;
    logic [7:0] m_scratch;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_bytes.delete(); m_lens.delete(); m_part.delete();
        m_drop = 0; m_ovf = 0; m_en = 0; m_ie = 0; m_scratch = 8'h00;
    endfunction

    function automatic int model_fill();
        return m_bytes.size() + m_part.size();
    endfunction

    function automatic logic [7:0] model_ready();
        return 8'((m_en && (m_drop || (model_fill() < DEPTH && m_lens.size() < SLOTS))) ? 1 : 0);
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            3'd0: v = {6'b0, m_ie, m_en};
            3'd1: v = {4'b0, model_fill() == 0, m_ovf, model_fill() == DEPTH, m_lens.size() != 0};
            3'd2: v = (m_lens.size() != 0) ? 8'(m_lens[0]) : 8'h00;
            3'd3: if (m_lens.size() != 0) begin
                v = m_bytes.pop_front();
                m_lens[0] = m_lens[0] - 1;
                if (m_lens[0] == 0) void'(m_lens.pop_front());
            end
            3'd4: v = m_scratch;
            3'd5: v = 8'(m_lens.size());
            3'd6: v = 8'hA5;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [7:0] d);
        if (a == 3'd0) begin
            m_en = d[0]; m_ie = d[1];
            if (d[2]) begin
                m_bytes.delete(); m_lens.delete(); m_part.delete(); m_drop = 0;
            end
        end
        if (a == 3'd1 && d[2]) m_ovf = 0;
        if (a == 3'd4) m_scratch = d;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic last);
        if (m_drop) begin
            if (last) m_drop = 0;
        end else begin
            m_part.push_back(d);
            if (last) begin
                m_lens.push_back(m_part.size());
                foreach (m_part[i]) m_bytes.push_back(m_part[i]);
                m_part.delete();
            end else if (model_fill() == DEPTH && m_lens.size() == 0) begin
                m_ovf = 1; m_drop = 1; m_part.delete();
            end
        end
    endfunction

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wr = 1'b1; wr_data = d;
        @(negedge clk);
        wr = 1'b0;
        model_write(a, d);
    endtask

    task automatic read_chk(input logic [2:0] a, input string tag);
        logic [7:0] exp;
        exp = model_read(a);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk(tag, rd_data, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited = 0;
        @(negedge clk);
        while (!pkt_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 8'(pkt_ready), 8'h01);
        if (pkt_ready) begin
            pkt_valid = 1'b1; pkt_data = d; pkt_last = last;
            @(posedge clk);
            #1;
            pkt_valid = 1'b0; pkt_last = 1'b0;
            model_accept(d, last);
        end
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1);
    endtask

    task automatic chk_int(input string tag);
        @(negedge clk);
        @(negedge clk);
        chk(tag, 8'(int_n), 8'((m_ie && m_lens.size() != 0) ? 0 : 1));
    endtask

    initial begin
        logic [7:0] exp;
        int op, len;
        model_reset();

        #12;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_int_n", 8'(int_n), 8'h01);
        chk("reset_pkt_ready", 8'(pkt_ready), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        read_chk(3'd6, "id");
        read_chk(3'd7, "reserved");
        read_chk(3'd0, "ctrl_reset");
        read_chk(3'd1, "status_reset");

        write_reg(3'd4, 8'h3C);
        read_chk(3'd4, "scratch");
        @(negedge clk);
        addr = 3'd4; wr = 1'b1; wr_data = 8'h55; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("wr_rd_same_cycle", rd_data, 8'h3C);
        model_write(3'd4, 8'h55);
        read_chk(3'd4, "scratch_after");
        write_reg(3'd7, 8'hFF);
        read_chk(3'd7, "reserved_after_wr");

        write_reg(3'd0, 8'h03);
        read_chk(3'd0, "ctrl_rw");
        chk("ready_enabled", 8'(pkt_ready), model_ready());
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        @(negedge clk);
        chk("int_n_lag", 8'(int_n), 8'h01);
        @(negedge clk);
        chk("int_n_low", 8'(int_n), 8'h00);
        read_chk(3'd5, "pkt_cnt_1");
        read_chk(3'd2, "rx_len_3");
        for (int i = 0; i < 3; i++) read_chk(3'd3, "rx_data_pkt1");
        read_chk(3'd5, "pkt_cnt_0");
        chk_int("int_n_release");
        read_chk(3'd3, "pop_empty");
        read_chk(3'd2, "rx_len_empty");

        send_pkt(2);
        send_pkt(4);
        read_chk(3'd5, "pkt_cnt_2");
        read_chk(3'd2, "rx_len_2");
        read_chk(3'd3, "pop_a0");
        read_chk(3'd3, "pop_a1");
        read_chk(3'd2, "rx_len_4");
        read_chk(3'd5, "pkt_cnt_after_a");
        for (int i = 0; i < 4; i++) read_chk(3'd3, "pop_b");

        for (int i = 0; i < 17; i++) send_byte(8'(i + 8'h40), 1'b0);
        read_chk(3'd1, "status_overflow");
        read_chk(3'd5, "pkt_cnt_ovf");
        write_reg(3'd1, 8'h04);
        read_chk(3'd1, "status_w1c");
        send_byte(8'hEE, 1'b1);
        read_chk(3'd5, "pkt_cnt_after_drop");
        read_chk(3'd1, "status_after_drop");

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            len = $urandom_range(1, 5);
            case (op)
                0, 1: if (model_fill() + len <= DEPTH && m_lens.size() < SLOTS) send_pkt(len);
                      else read_chk(3'd3, "rnd_pop_full");
                2, 3: read_chk(3'd3, "rnd_pop");
                4: read_chk(3'($urandom_range(0, 7)), "rnd_reg");
                default: begin
                    write_reg(3'd4, 8'($urandom));
                    chk_int("rnd_int_n");
                end
            endcase
        end
        read_chk(3'd5, "rnd_pkt_cnt");
        while (m_lens.size() != 0) read_chk(3'd3, "rnd_drain");
        read_chk(3'd1, "status_drained");

        for (int i = 0; i < SLOTS; i++) send_pkt(3);
        @(negedge clk);
        chk("ready_slots_full", 8'(pkt_ready), model_ready());
        read_chk(3'd1, "status_slots_full");
        write_reg(3'd0, 8'h07);
        read_chk(3'd5, "pkt_cnt_flush");
        read_chk(3'd1, "status_flush");
        read_chk(3'd0, "ctrl_flush_reads_0");

        send_pkt(8);
        send_pkt(8);
        @(negedge clk);
        chk("ready_bytes_full", 8'(pkt_ready), model_ready());
        read_chk(3'd1, "status_bytes_full");
        write_reg(3'd0, 8'h07);

        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b0);
        exp = model_read(3'd3);
        @(negedge clk);
        addr = 3'd3; rd = 1'b1; pkt_valid = 1'b1; pkt_data = 8'h99; pkt_last = 1'b1;
        @(negedge clk);
        rd = 1'b0; pkt_valid = 1'b0; pkt_last = 1'b0;
        model_accept(8'h99, 1'b1);
        chk("pop_and_last", rd_data, exp);
        read_chk(3'd5, "pkt_cnt_net");
        read_chk(3'd2, "rx_len_net");
        read_chk(3'd3, "pop_net0");
        read_chk(3'd3, "pop_net1");
        read_chk(3'd5, "pkt_cnt_net_end");

        send_byte(8'h5A, 1'b1);
        chk_int("int_n_before_rst");
        read_chk(3'd6, "id_before_rst");
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pkt_ready", 8'(pkt_ready), 8'h00);
        chk("rst_int_n", 8'(int_n), 8'h01);
        chk("rst_rd_data", rd_data, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        read_chk(3'd1, "status_post_rst");
        read_chk(3'd5, "pkt_cnt_post_rst");
        read_chk(3'd0, "ctrl_post_rst");
        read_chk(3'd4, "scratch_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/modport_block.md
Name: modport_block

Overview:
- Byte-wide CPU register block fronting a receive packet buffer in the packet divider/reorder datapath.
- Upstream pushes packet bytes into an internal byte FIFO, with packet lengths kept in a small length FIFO.
- Software reads the packets through an 8-register map (3-bit address, separate wr/rd strobes).
- Active-low int_n flags that a complete packet is ready.

Parameters:
- DEPTH, 16, byte FIFO entries (power of 2, max packet length).
- PKT_SLOTS, 4, length-FIFO entries (max stored complete packets).
- ID_VALUE, 8'hA5, constant returned at address 6.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  3  register address for both reads and writes
- wr  in  1  write strobe, one register write per cycle high
- wr_data  in  8  write data
- rd  in  1  read strobe
- rd_data  out  8  registered read data
- int_n  out  1  active-low interrupt: rx packet available
- pkt_valid  in  1  upstream byte valid
- pkt_data  in  8  upstream byte
- pkt_last  in  1  marks final byte of packet
- pkt_ready  out  1  block accepts byte this cycle

Behaviour:
- Reset (async, rst=1): all registers, FIFOs and counters cleared.
  - Output reset values: rd_data=0, int_n=1, pkt_ready=0.
- Register map (unlisted bits read 0):
  - 0 CTRL RW: bit0 enable, bit1 int_en, bit2 flush. Flush is self-clearing and always reads 0.
  - 1 STATUS RO except bit2 W1C:
    - bit0 pkt_avail (pkt_cnt!=0)
    - bit1 full (byte FIFO full)
    - bit2 overflow (sticky)
    - bit3 empty (byte FIFO empty)
  - 2 RX_LEN RO: remaining unread bytes of head packet; 0 if none.
  - 3 RX_DATA RO with side effect: pops next head-packet byte.
  - 4 SCRATCH RW, 8 bits.
  - 5 PKT_CNT RO: number of complete packets stored (0..PKT_SLOTS).
  - 6 ID RO: ID_VALUE.
  - 7 reserved: reads 0, writes ignored.
- Write timing: write takes effect at the rising edge where wr=1.
- Read timing: on the edge where rd=1, rd_data loads the addressed value, so it is valid from that edge (1-cycle latency).
  - rd_data holds its value when rd=0.
- wr and rd in the same cycle: both execute; rd_data returns the pre-write value.
- RX_DATA pop rules:
  - With pkt_cnt>0, a pop decrements RX_LEN.
  - When RX_LEN reaches 0, the length FIFO pops, pkt_cnt decrements, and RX_LEN loads the next packet length (or 0).
  - A pop with pkt_cnt=0 returns 8'h00 and has no side effects.
- Input handshake:
  - pkt_ready = enable & !byte_full & !(len_fifo_full).
  - A byte is accepted on an edge with pkt_valid & pkt_ready.
  - The running length counter increments per accepted byte.
  - On an accepted pkt_last, length+1 is pushed to the length FIFO and the counter clears.
  - Bytes of an unterminated packet are never visible to software.
- Overflow: byte FIFO becomes full while a partial packet is in progress and pkt_cnt=0:
  - Partial bytes are discarded (write pointer rewinds to packet start, counter cleared) and overflow is set.
  - The remaining bytes of that packet, through pkt_last, are dropped; pkt_ready=1 while dropping.
- Flush (write CTRL bit2=1): clears both FIFOs, pkt_cnt, RX_LEN and the partial counter in that cycle. Overflow is unaffected.
- int_n: registered, = !(int_en & pkt_cnt!=0); it updates the cycle after the condition changes.
- Simultaneous accepted pkt_last and final pop: pkt_cnt net unchanged, and lengths stay consistent.
- enable=0 blocks input only; reads still work.

Test Plan:
- Reset → rd_data=0, int_n=1, pkt_ready=0; read addr6 → 8'hA5; read addr7 → 0.
- Write 8'h3C to addr4, read addr4 → 8'h3C; in the same cycle write 8'h55 and read addr4 → rd_data=8'h3C, next read → 8'h55.
- CTRL=8'h03, then push a 3-byte packet 11,22,33 with last on 33:
  - int_n low the cycle after the last byte; PKT_CNT=1, RX_LEN=3.
  - Three RX_DATA reads → 11,22,33; then PKT_CNT=0, int_n=1.
- Push packets of length 2 and 4 back-to-back: PKT_CNT=2, RX_LEN=2, and after 2 pops RX_LEN=4.
- Push 17 bytes without last, with DEPTH=16: STATUS bit2=1, PKT_CNT=0; write 8'h04 to addr1 → bit2 clears.
- Store 4 packets: pkt_ready=0 and STATUS.full reflects the FIFO; write CTRL bit2 → PKT_CNT=0, STATUS empty=1. Assert rst mid-packet → all cleared immediately.
